mips_multicycle_ctrl: RTL and testbench

- Multicycle MIPS control unit. It is the driving end of the ALU interface: it generates the 4-bit aluCode and operand-select controls, and consumes the ALU zero flag for branches.
- Sequences each instruction through fetch/decode/execute/memory/writeback and raises datapath enables for register file, memory, IR and PC.
- Sits between instruction register (opcode/funct) and the datapath muxes around alu_32_bit.

---
 rtl/mips_multicycle_ctrl_pkg.sv | 58 +++++
 rtl/mips_multicycle_ctrl_if.sv | 36 +++
 rtl/mips_multicycle_ctrl_alu_control_decode.sv | 42 ++++
 rtl/mips_multicycle_ctrl.sv | 154 +++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funct codes,
// ALU operation codes, mux select values and FSM state numbering.
package mips_multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_IMM   = 2'b11
  } aluop_e;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_IMM_EXEC  = 4'd10,
    S_IMM_WB    = 4'd11
  } state_e;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller (master) and the
// datapath around the ALU, register file, memory, IR and PC (slave).
interface mips_multicycle_ctrl_if #(parameter int STATE_W = 4);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               zero;
  logic [3:0]         aluCode;
  logic               aluSrcA;
  logic [1:0]         aluSrcB;
  logic               iorD;
  logic               memRead;
  logic               memWrite;
  logic               irWrite;
  logic               regWrite;
  logic               regDst;
  logic               memToReg;
  logic               pcWrite;
  logic               pcWriteCond;
  logic [1:0]         pcSource;
  logic               pcEn;
  logic [STATE_W-1:0] stateOut;

  modport master (
    input  opcode, funct, zero,
    output aluCode, aluSrcA, aluSrcB, iorD, memRead, memWrite, irWrite,
           regWrite, regDst, memToReg, pcWrite, pcWriteCond, pcSource,
           pcEn, stateOut
  );

  modport slave (
    output opcode, funct, zero,
    input  aluCode, aluSrcA, aluSrcB, iorD, memRead, memWrite, irWrite,
           regWrite, regDst, memToReg, pcWrite, pcWriteCond, pcSource,
           pcEn, stateOut
  );
endinterface

// File: rtl/mips_multicycle_ctrl_alu_control_decode.sv
// ALU control decode: maps the FSM's aluOp plus funct/opcode to a 4-bit
// aluCode, flagging funct/opcode values that have no ALU meaning.
module alu_control_decode
  import mips_multicycle_ctrl_pkg::*;
(
  input  aluop_e     aluOp,
  input  logic [5:0] funct,
  input  logic [5:0] opcode,
  output logic [3:0] aluCode,
  output logic       legal
);

  always_comb begin
    aluCode = ALU_ADD;
    legal   = 1'b1;
    case (aluOp)
      ALUOP_ADD: aluCode = ALU_ADD;
      ALUOP_SUB: aluCode = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  aluCode = ALU_ADD;
          FN_SUB:  aluCode = ALU_SUB;
          FN_AND:  aluCode = ALU_AND;
          FN_OR:   aluCode = ALU_OR;
          FN_SLT:  aluCode = ALU_SLT;
          default: legal   = 1'b0;
        endcase
      end
      ALUOP_IMM: begin
        case (opcode)
          OP_ADDI: aluCode = ALU_ADD;
          OP_ANDI: aluCode = ALU_AND;
          OP_ORI:  aluCode = ALU_OR;
          OP_SLTI: aluCode = ALU_SLT;
          default: legal   = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM driving ALU operand/operation selects and the
// datapath enables. Define ALU_IMM_EN to add addi/andi/ori/slti execution.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_multicycle_ctrl_if.master bus
);

  state_e     state_q, state_d;
  logic       legal_q, legal_d;
  aluop_e     alu_op;
  logic [3:0] dec_code;
  logic       dec_legal;

  logic       mem_read, mem_write, ir_write, reg_write;
  logic       reg_dst, mem_to_reg, pc_write, pc_write_cond;
  logic [1:0] pc_source, alu_src_b;
  logic       alu_src_a, ior_d;

  alu_control_decode u_alu_dec (
    .aluOp   (alu_op),
    .funct   (bus.funct),
    .opcode  (bus.opcode),
    .aluCode (dec_code),
    .legal   (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Funct legality is latched in EXECUTE so the writeback state stays Moore.
  always_ff @(posedge clk) begin
    legal_q <= legal_d;
  end

  always_comb begin
    legal_d = (state_q == S_EXECUTE) ? dec_legal : legal_q;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef ALU_IMM_EN
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMM_EXEC;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = S_MEM_WB;
      S_EXECUTE:   state_d = S_ALU_WB;
      S_IMM_EXEC:  state_d = S_IMM_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCSRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    ior_d         = 1'b0;
    alu_op        = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      S_DECODE:   alu_src_b = SRCB_IMM_SH;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        ior_d    = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        ior_d     = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        reg_dst   = 1'b1;
        reg_write = legal_q;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      S_IMM_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_IMM;
      end
      S_IMM_WB:   reg_write = 1'b1;
      default: ;
    endcase
  end

  // Every strobe is masked while reset is high so an abandoned instruction
  // cannot touch memory, registers or PC in the reset cycle.
  assign bus.memRead     = mem_read & ~reset;
  assign bus.memWrite    = mem_write & ~reset;
  assign bus.irWrite     = ir_write & ~reset;
  assign bus.regWrite    = reg_write & ~reset;
  assign bus.pcWrite     = pc_write & ~reset;
  assign bus.pcWriteCond = pc_write_cond & ~reset;
  assign bus.pcEn        = ~reset & (pc_write | (pc_write_cond & bus.zero));
  assign bus.regDst      = reg_dst;
  assign bus.memToReg    = mem_to_reg;
  assign bus.pcSource    = pc_source;
  assign bus.aluSrcA     = alu_src_a;
  assign bus.aluSrcB     = alu_src_b;
  assign bus.iorD        = ior_d;
  assign bus.aluCode     = dec_code;
  assign bus.stateOut    = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: instruction vector table, reset corner
// cases and random instruction streams against a per-instruction model.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
  localparam logic [5:0] T_BEQ = 6'b000100, T_J = 6'b000010;
  localparam logic [5:0] T_ADDI = 6'b001000, T_ANDI = 6'b001100;
  localparam logic [5:0] T_ORI = 6'b001101, T_SLTI = 6'b001010;
`ifdef ALU_IMM_EN
  localparam int IMM_LAT = 4;
`else
  localparam int IMM_LAT = 2;
`endif

  typedef struct packed {
    logic [3:0] alu_code;
    logic       src_a;
    logic [1:0] src_b;
    logic       iord;
    logic       mem_rd, mem_wr, ir_wr, reg_wr;
    logic       reg_dst, mem_to_reg, pc_wr, pc_wc;
    logic [1:0] pc_src;
    logic       pc_en;
  } ctl_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    bit         z;
    int         lat;
    string      name;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl_if #(.STATE_W(4)) bus ();
  mips_multicycle_ctrl #(.STATE_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic ctl_t sample();
    ctl_t c;
    c.alu_code = bus.aluCode;  c.src_a = bus.aluSrcA;   c.src_b = bus.aluSrcB;
    c.iord = bus.iorD;         c.mem_rd = bus.memRead;  c.mem_wr = bus.memWrite;
    c.ir_wr = bus.irWrite;     c.reg_wr = bus.regWrite; c.reg_dst = bus.regDst;
    c.mem_to_reg = bus.memToReg; c.pc_wr = bus.pcWrite; c.pc_wc = bus.pcWriteCond;
    c.pc_src = bus.pcSource;   c.pc_en = bus.pcEn;
    return c;
  endfunction

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_ctl(input string name, input ctl_t e, input ctl_t m);
    ctl_t a;
    a = sample();
    n_tests++;
    if ((a & m) !== (e & m)) begin
      n_fail++;
      $display("FAIL %s: got ctl %h expected %h (care bits %h)", name, a, e, m);
    end
  endtask

  function automatic bit fn_lookup(input logic [5:0] fn, output logic [3:0] code);
    logic [5:0] keys [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [3:0] vals [5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};
    code = 4'b0010;
    for (int i = 0; i < 5; i++) if (keys[i] == fn) begin code = vals[i]; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic logic [3:0] imm_code(input logic [5:0] op);
    logic [5:0] keys [4] = '{T_ADDI, T_ANDI, T_ORI, T_SLTI};
    logic [3:0] vals [4] = '{4'b0010, 4'b0000, 4'b0001, 4'b0111};
    for (int i = 0; i < 4; i++) if (keys[i] == op) return vals[i];
    return 4'b0010;
  endfunction

  // Expected controls for a state; m marks the bits with a defined value there.
  function automatic void exp_ctl(input int st, input logic [5:0] op, input logic [5:0] fn,
                                  input bit z, input bit rst, output ctl_t e, output ctl_t m);
    logic [3:0] code;
    bit legal;
    e = '0; m = '0;
    m.mem_rd = 1; m.mem_wr = 1; m.ir_wr = 1; m.reg_wr = 1;
    m.pc_wr = 1; m.pc_wc = 1; m.pc_en = 1;
    legal = fn_lookup(fn, code);
    case (st)
      0: begin e.mem_rd = 1; e.ir_wr = 1; e.pc_wr = 1; e.src_b = 2'b01; e.alu_code = 4'b0010;
               m.src_a = 1; m.src_b = '1; m.alu_code = '1; m.pc_src = '1; end
      1: begin e.src_b = 2'b11; e.alu_code = 4'b0010; m.src_a = 1; m.src_b = '1; m.alu_code = '1; end
      2: begin e.src_a = 1; e.src_b = 2'b10; e.alu_code = 4'b0010;
               m.src_a = 1; m.src_b = '1; m.alu_code = '1; end
      3: begin e.mem_rd = 1; e.iord = 1; m.iord = 1; end
      4: begin e.reg_wr = 1; e.mem_to_reg = 1; m.reg_dst = 1; m.mem_to_reg = 1; end
      5: begin e.mem_wr = 1; e.iord = 1; m.iord = 1; end
      6: begin e.src_a = 1; e.alu_code = code; m.src_a = 1; m.src_b = '1;
               if (legal) m.alu_code = '1; end
      7: begin e.reg_wr = legal; e.reg_dst = 1; m.reg_dst = 1; m.mem_to_reg = 1; end
      8: begin e.src_a = 1; e.alu_code = 4'b0110; e.pc_wc = 1; e.pc_src = 2'b01;
               m.src_a = 1; m.src_b = '1; m.alu_code = '1; m.pc_src = '1; end
      9: begin e.pc_wr = 1; e.pc_src = 2'b10; m.pc_src = '1; end
      10: begin e.src_a = 1; e.src_b = 2'b10; e.alu_code = imm_code(op);
                m.src_a = 1; m.src_b = '1; m.alu_code = '1; end
      11: begin e.reg_wr = 1; m.reg_dst = 1; m.mem_to_reg = 1; end
      default: begin e.alu_code = 4'b0010; m.alu_code = '1; end
    endcase
    if (rst) begin e.mem_rd = 0; e.mem_wr = 0; e.ir_wr = 0; e.reg_wr = 0; e.pc_wr = 0; e.pc_wc = 0; end
    e.pc_en = e.pc_wr | (e.pc_wc & z);
  endfunction

  task automatic get_path(input logic [5:0] op, output int p[6], output int len);
    p = '{0, 1, 0, 0, 0, 0};
    len = 2;
    case (op)
      T_LW:  begin p = '{0, 1, 2, 3, 4, 0}; len = 5; end
      T_SW:  begin p = '{0, 1, 2, 5, 0, 0}; len = 4; end
      T_R:   begin p = '{0, 1, 6, 7, 0, 0}; len = 4; end
      T_BEQ: begin p = '{0, 1, 8, 0, 0, 0}; len = 3; end
      T_J:   begin p = '{0, 1, 9, 0, 0, 0}; len = 3; end
`ifdef ALU_IMM_EN
      T_ADDI, T_ANDI, T_ORI, T_SLTI: begin p = '{0, 1, 10, 11, 0, 0}; len = 4; end
`endif
      default: ;
    endcase
  endtask

  // Runs one instruction from FETCH until the DUT comes back to FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                           input int exp_lat, input string tag);
    int p[6];
    int len, cyc, st;
    ctl_t e, m;
    get_path(op, p, len);
    if (exp_lat < 0) exp_lat = len;
    bus.opcode = op; bus.funct = fn; bus.zero = z;
    cyc = 0;
    do begin
      #1;
      st = (cyc < len) ? p[cyc] : 15;
      check_int($sformatf("%s state c%0d", tag, cyc), int'(bus.stateOut), st);
      exp_ctl(st, op, fn, z, 1'b0, e, m);
      check_ctl($sformatf("%s ctl st%0d", tag, st), e, m);
      step();
      cyc++;
    end while (bus.stateOut != 4'd0 && cyc < 12);
    check_int({tag, " latency"}, cyc, exp_lat);
  endtask

  vec_t vecs[14];

  initial begin
    ctl_t e, m;
    logic [5:0] ops [9] = '{T_LW, T_SW, T_R, T_BEQ, T_J, T_ADDI, T_ANDI, T_ORI, T_SLTI};
    logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    vecs[0]  = '{T_LW,     6'd0,      1'b0, 5, "lw"};
    vecs[1]  = '{T_SW,     6'd0,      1'b0, 4, "sw"};
    vecs[2]  = '{T_R,      6'b101010, 1'b0, 4, "slt"};
    vecs[3]  = '{T_R,      6'b111111, 1'b0, 4, "r_badfn"};
    vecs[4]  = '{T_R,      6'b100000, 1'b1, 4, "add"};
    vecs[5]  = '{T_R,      6'b100010, 1'b0, 4, "sub"};
    vecs[6]  = '{T_R,      6'b100100, 1'b0, 4, "and"};
    vecs[7]  = '{T_R,      6'b100101, 1'b0, 4, "or"};
    vecs[8]  = '{T_BEQ,    6'd0,      1'b1, 3, "beq_taken"};
    vecs[9]  = '{T_BEQ,    6'd0,      1'b0, 3, "beq_not"};
    vecs[10] = '{T_J,      6'd0,      1'b0, 3, "j"};
    vecs[11] = '{6'b111111, 6'd0,     1'b0, 2, "undef"};
    vecs[12] = '{T_ORI,    6'd0,      1'b0, IMM_LAT, "ori"};
    vecs[13] = '{T_SLTI,   6'd0,      1'b1, IMM_LAT, "slti"};

    bus.opcode = T_LW; bus.funct = 6'd0; bus.zero = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_int("reset state", int'(bus.stateOut), 0);
    exp_ctl(0, T_LW, 6'd0, 1'b1, 1'b1, e, m);
    check_ctl("reset strobes", e, m);
    reset = 1'b0;

    foreach (vecs[i]) run_instr(vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].lat, vecs[i].name);

    // Reset arriving in MEM_WRITE abandons the store.
    bus.opcode = T_SW; bus.funct = 6'd0; bus.zero = 1'b0;
    repeat (3) step();
    check_int("sw pre-reset state", int'(bus.stateOut), 5);
    reset = 1'b1;
    #1;
    exp_ctl(5, T_SW, 6'd0, 1'b0, 1'b1, e, m);
    check_ctl("reset in MEM_WRITE", e, m);
    step();
    check_int("state after reset", int'(bus.stateOut), 0);
    exp_ctl(0, T_SW, 6'd0, 1'b0, 1'b1, e, m);
    check_ctl("fetch held in reset", e, m);
    reset = 1'b0;

    // Reset arriving in MEM_READ abandons the load, then a clean lw follows.
    bus.opcode = T_LW;
    #1;
    repeat (3) step();
    check_int("lw pre-reset state", int'(bus.stateOut), 3);
    reset = 1'b1;
    #1;
    exp_ctl(3, T_LW, 6'd0, 1'b0, 1'b1, e, m);
    check_ctl("reset in MEM_READ", e, m);
    step();
    reset = 1'b0;
    run_instr(T_LW, 6'd0, 1'b0, 5, "lw_after_reset");

    for (int k = 0; k < 300; k++) begin
      logic [5:0] op, fn;
      int idx;
      idx = $urandom_range(0, 9);
      op = (idx == 9) ? 6'($urandom) : ops[idx];
      fn = ($urandom_range(0, 1) == 1) ? fns[$urandom_range(0, 4)] : 6'($urandom);
      run_instr(op, fn, 1'($urandom), -1, $sformatf("rnd%0d op%b fn%b", k, op, fn));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
